piece_move_ctrl: RTL and testbench
==================================

// Module: piece_move_ctrl
// PURPOSE
//  Active-piece controller; initiator side of the board's move-validity check.
//  Holds the falling piece as a full-board bitmap and turns move requests into candidate
//  next_location bitmaps. Samples the checker's not_valid, then commits or rejects each
//  candidate. When a downward move fails, it emits a one-cycle lock of the piece into the
//  background. Sits between the input/gravity logic and the board/background register.
// PARAMETERS
//  PLAY_WIDTH   10  board columns; bit index = col + PLAY_WIDTH*row
//  PLAY_HEIGHT  15  board rows; row PLAY_HEIGHT-1 is the floor, row 0 is the spawn edge
//  PIX_PER_BLK  32  pixels per block (pass-through for the display; unused here)
// PORTS  (N = PLAY_WIDTH*PLAY_HEIGHT)
//  clk             in   1  system clock, all state on posedge
//  reset           in   1  asynchronous, active-low (asserted at 0)
//  spawn_req       in   1  load spawn_location as the new piece (honoured only in EMPTY)
//  spawn_location  in   N  bitmap of the new piece
//  req_left        in   1  move one column toward col 0
//  req_right       in   1  move one column toward col PLAY_WIDTH-1
//  req_down        in   1  move one row toward the floor (gravity tick or user)
//  req_drop        in   1  hard drop: repeat down until rejected, then lock
//  not_valid       in   1  checker verdict on next_location (combinational, same cycle)
//  next_location   out  N  registered candidate presented to the checker
//  cur_location    out  N  committed piece bitmap (for the display)
//  busy            out  1  1 when not in READY; req_* are ignored while busy=1
//  move_done       out  1  1-cycle pulse: candidate accepted and committed
//  move_rejected   out  1  1-cycle pulse: left/right/down candidate rejected
//  lock_valid      out  1  1-cycle pulse; lock_location is valid
//  lock_location   out  N  piece bitmap to OR into the background
//  game_over       out  1  sticky; set when a spawn is rejected, cleared only by reset
// BEHAVIOUR
//  Reset: state=EMPTY; every N-bit output=0; all pulse outputs=0; game_over=0; busy=1.
//  FSM states: EMPTY, READY, CHECK, LOCK, OVER.
//   EMPTY: on spawn_req && !game_over, next_location<=spawn_location, kind<=SPAWN, go to CHECK.
//   READY: busy=0. Requests are sampled at the edge with priority drop > down > left > right.
//          The candidate is registered into next_location and the FSM goes to CHECK.
//   CHECK: the verdict is the sampled not_valid OR a forced reject. On the edge:
//    SPAWN ok  -> cur<=next; go to READY.          SPAWN bad -> game_over<=1; go to OVER.
//    L/R/D ok  -> cur<=next; move_done; go to READY.
//    L/R bad   -> move_rejected; go to READY (cur unchanged).
//    DOWN bad  -> move_rejected; go to LOCK.
//    DROP ok   -> cur<=next; next<=cur_next<<W; stay in CHECK (one row per cycle).
//    DROP bad  -> go to LOCK (no move_rejected).
//   LOCK:  lock_valid=1, lock_location=cur; on the next edge cur<=0, next<=0; go to EMPTY.
//   OVER:  absorbing state; all requests are ignored.
//  Candidates (shift in the N-bit domain, zero-filled):
//   left: cur>>1;  right: cur<<1;  down: cur<<PLAY_WIDTH.
//  Forced reject in CHECK, independent of not_valid:
//   left:  cur & COL0_MASK != 0
//   right: cur & COLW_MASK != 0
//   down/drop: cur & FLOOR_MASK != 0
//   These block wrap-around and shift-out that the checker cannot detect.
//  Latency: request at edge T -> candidate visible T..T+1 -> commit/reject at edge T+1.
//   busy=0 again in the cycle after commit. Hard drop over k rows locks at edge T+k+1.
//  Simultaneous events:
//   - Multiple requests: only the highest-priority one is taken; the rest are dropped
//     (not queued).
//   - spawn_req outside EMPTY is ignored.
//   - Async reset mid-CHECK/LOCK aborts the operation; no lock pulse is emitted.
//  not_valid is only meaningful in CHECK; it is ignored in every other state.
// STRUCTURE
//  Package tetris_pkg holds:
//   - mv_state_t enum
//   - mv_kind_t enum {SPAWN, LEFT, RIGHT, DOWN, DROP}
//   - functions col0_mask(W,H), colw_mask(W,H), floor_mask(W,H) returning N-bit masks
//  Sub-module piece_shifter (combinational): inputs cur, kind; outputs candidate and
//   force_reject. Keeps the FSM body free of shift/mask logic.
// TESTING  (W=10, H=15, checker model instantiated in the bench)
//  1 spawn bits[3:0], empty background -> CHECK then READY, cur=0xF, busy=0 two cycles
//    after spawn_req.
//  2 cur bits[123:120], req_left -> next=[122:119] -> forced reject (bit 120 is col 0):
//    move_rejected=1, cur unchanged.
//  3 cur bit 4, req_right x5 -> bits 5..9 accepted; 6th request is rejected
//    (col W-1), no wrap to bit 10.
//  4 background[149:134]=1s, cur bit 114, req_drop -> moves to bit 124, rejects bit 134;
//    lock_valid with lock_location bit 124; state EMPTY.
//  5 spawn onto an occupied background bit -> game_over=1 sticky; later spawn_req and
//    req_* have no effect.
//  6 reset driven low during a drop in CHECK -> all outputs 0 immediately, no lock_valid;
//    normal operation resumes after reset deasserts.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and board-mask helpers for the active-piece controller.
// Masks are built in a fixed-width vector; callers keep the low W*H bits.
package tetris_pkg;

    localparam int MASK_BITS = 256;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_READY,
        ST_CHECK,
        ST_LOCK,
        ST_OVER
    } mv_state_t;

    typedef enum logic [2:0] {
        SPAWN,
        LEFT,
        RIGHT,
        DOWN,
        DROP
    } mv_kind_t;

    function automatic logic [MASK_BITS-1:0] col0_mask(input int w, input int h);
        logic [MASK_BITS-1:0] m;
        m = '0;
        for (int r = 0; r < h; r++) begin
            m[w*r] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MASK_BITS-1:0] colw_mask(input int w, input int h);
        logic [MASK_BITS-1:0] m;
        m = '0;
        for (int r = 0; r < h; r++) begin
            m[w*r + w - 1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MASK_BITS-1:0] floor_mask(input int w, input int h);
        logic [MASK_BITS-1:0] m;
        m = '0;
        for (int c = 0; c < w; c++) begin
            m[w*(h-1) + c] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/piece_shifter.sv
// Combinational candidate generator: shifts the piece for a move kind and flags
// moves that would wrap across a row edge or fall off the floor.
module piece_shifter
    import tetris_pkg::*;
#(
    parameter int PLAY_WIDTH  = 10,
    parameter int PLAY_HEIGHT = 15
) (
    input  logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] cur,
    input  mv_kind_t                          kind,
    output logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] candidate,
    output logic                              force_reject
);

    localparam int N = PLAY_WIDTH * PLAY_HEIGHT;

    localparam logic [MASK_BITS-1:0] COL0_FULL  = col0_mask(PLAY_WIDTH, PLAY_HEIGHT);
    localparam logic [MASK_BITS-1:0] COLW_FULL  = colw_mask(PLAY_WIDTH, PLAY_HEIGHT);
    localparam logic [MASK_BITS-1:0] FLOOR_FULL = floor_mask(PLAY_WIDTH, PLAY_HEIGHT);
    localparam logic [N-1:0] COL0_MASK  = COL0_FULL[N-1:0];
    localparam logic [N-1:0] COLW_MASK  = COLW_FULL[N-1:0];
    localparam logic [N-1:0] FLOOR_MASK = FLOOR_FULL[N-1:0];

    always_comb begin
        candidate    = '0;
        force_reject = 1'b0;
        case (kind)
            LEFT: begin
                candidate    = cur >> 1;
                force_reject = |(cur & COL0_MASK);
            end
            RIGHT: begin
                candidate    = cur << 1;
                force_reject = |(cur & COLW_MASK);
            end
            DOWN, DROP: begin
                candidate    = cur << PLAY_WIDTH;
                force_reject = |(cur & FLOOR_MASK);
            end
            default: begin
                candidate    = '0;
                force_reject = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/piece_move_ctrl.sv
// Active-piece controller: registers move candidates for the board checker, then
// commits, rejects, or locks the piece into the background based on the verdict.
module piece_move_ctrl
    import tetris_pkg::*;
#(
    parameter int PLAY_WIDTH  = 10,
    parameter int PLAY_HEIGHT = 15,
    parameter int PIX_PER_BLK = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              spawn_req,
    input  logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] spawn_location,
    input  logic                              req_left,
    input  logic                              req_right,
    input  logic                              req_down,
    input  logic                              req_drop,
    input  logic                              not_valid,
    output logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] next_location,
    output logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] cur_location,
    output logic                              busy,
    output logic                              move_done,
    output logic                              move_rejected,
    output logic                              lock_valid,
    output logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] lock_location,
    output logic                              game_over
);

    localparam int N = PLAY_WIDTH * PLAY_HEIGHT;

    // Block size only matters to the display path that shares this parameter set.
    if (PIX_PER_BLK < 1) begin : g_pix_blk_unused
    end

    mv_state_t state, state_n;
    mv_kind_t  kind, kind_n, req_kind, kind_sel;
    logic [N-1:0] cur_n, next_n, candidate;
    logic         done_n, rej_n, over_n;
    logic         has_req, force_reject, verdict_bad;

    always_comb begin
        req_kind = SPAWN;
        if (req_drop)       req_kind = DROP;
        else if (req_down)  req_kind = DOWN;
        else if (req_left)  req_kind = LEFT;
        else if (req_right) req_kind = RIGHT;
    end

    assign has_req  = req_drop | req_down | req_left | req_right;
    // One shifter serves both phases: the requested move in READY, the pending move in CHECK.
    assign kind_sel = (state == ST_CHECK) ? kind : req_kind;

    piece_shifter #(
        .PLAY_WIDTH  (PLAY_WIDTH),
        .PLAY_HEIGHT (PLAY_HEIGHT)
    ) u_shifter (
        .cur          (cur_location),
        .kind         (kind_sel),
        .candidate    (candidate),
        .force_reject (force_reject)
    );

    assign verdict_bad = not_valid | force_reject;

    always_comb begin
        state_n = state;
        kind_n  = kind;
        cur_n   = cur_location;
        next_n  = next_location;
        done_n  = 1'b0;
        rej_n   = 1'b0;
        over_n  = game_over;
        case (state)
            ST_EMPTY: begin
                if (spawn_req && !game_over) begin
                    next_n  = spawn_location;
                    kind_n  = SPAWN;
                    state_n = ST_CHECK;
                end
            end
            ST_READY: begin
                if (has_req) begin
                    next_n  = candidate;
                    kind_n  = req_kind;
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                case (kind)
                    SPAWN: begin
                        if (verdict_bad) begin
                            over_n  = 1'b1;
                            state_n = ST_OVER;
                        end else begin
                            cur_n   = next_location;
                            state_n = ST_READY;
                        end
                    end
                    LEFT, RIGHT: begin
                        if (verdict_bad) begin
                            rej_n = 1'b1;
                        end else begin
                            cur_n  = next_location;
                            done_n = 1'b1;
                        end
                        state_n = ST_READY;
                    end
                    DOWN: begin
                        if (verdict_bad) begin
                            rej_n   = 1'b1;
                            state_n = ST_LOCK;
                        end else begin
                            cur_n   = next_location;
                            done_n  = 1'b1;
                            state_n = ST_READY;
                        end
                    end
                    DROP: begin
                        // Hard drop keeps stepping one row per cycle until the checker refuses.
                        if (verdict_bad) begin
                            state_n = ST_LOCK;
                        end else begin
                            cur_n  = next_location;
                            next_n = next_location << PLAY_WIDTH;
                        end
                    end
                    default: state_n = ST_READY;
                endcase
            end
            ST_LOCK: begin
                cur_n   = '0;
                next_n  = '0;
                state_n = ST_EMPTY;
            end
            ST_OVER: state_n = ST_OVER;
            default: state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_EMPTY;
            kind          <= SPAWN;
            cur_location  <= '0;
            next_location <= '0;
            move_done     <= 1'b0;
            move_rejected <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            kind          <= kind_n;
            cur_location  <= cur_n;
            next_location <= next_n;
            move_done     <= done_n;
            move_rejected <= rej_n;
            game_over     <= over_n;
        end
    end

    assign busy          = (state != ST_READY);
    assign lock_valid    = (state == ST_LOCK);
    assign lock_location = lock_valid ? cur_location : '0;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Bench for piece_move_ctrl: checker model over a background bitmap, a row/column
// reference model of the piece, and a scoreboard fed by stimulus and drained by a monitor.
module tb_piece_move_ctrl;

    localparam int W = 10;
    localparam int H = 15;
    localparam int N = W * H;
    localparam int EV_DONE = 0;
    localparam int EV_REJ  = 1;
    localparam int EV_LOCK = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         spawn_req;
    logic [N-1:0] spawn_location;
    logic         req_left, req_right, req_down, req_drop;
    logic         not_valid;
    logic [N-1:0] next_location, cur_location, lock_location;
    logic         busy, move_done, move_rejected, lock_valid, game_over;

    logic [N-1:0] bg;
    logic [N-1:0] model_cur;
    bit           model_live;

    typedef struct {
        int           ev;
        logic [N-1:0] loc;
    } ev_t;
    ev_t exp_q[$];

    int total = 0;
    int bad   = 0;

    piece_move_ctrl #(
        .PLAY_WIDTH  (W),
        .PLAY_HEIGHT (H),
        .PIX_PER_BLK (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .spawn_req      (spawn_req),
        .spawn_location (spawn_location),
        .req_left       (req_left),
        .req_right      (req_right),
        .req_down       (req_down),
        .req_drop       (req_drop),
        .not_valid      (not_valid),
        .next_location  (next_location),
        .cur_location   (cur_location),
        .busy           (busy),
        .move_done      (move_done),
        .move_rejected  (move_rejected),
        .lock_valid     (lock_valid),
        .lock_location  (lock_location),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    // Board checker: a candidate is invalid when it overlaps the background.
    assign not_valid = |(next_location & bg);

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_check(input int ev, input logic [N-1:0] loc, input string name);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected pulse at %h, scoreboard empty", name, loc);
        end else begin
            e = exp_q.pop_front();
            if (e.ev != ev || e.loc !== loc) begin
                bad++;
                $display("FAIL %s: got event %0d loc %h expected event %0d loc %h",
                         name, ev, loc, e.ev, e.loc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (move_done)     pop_check(EV_DONE, cur_location, "move_done");
            if (move_rejected) pop_check(EV_REJ, cur_location, "move_rejected");
            if (lock_valid)    pop_check(EV_LOCK, lock_location, "lock_valid");
        end
    end

    // Reference move: relocate every block by (dr, dc) on the row/column grid.
    function automatic logic [N-1:0] shift_piece(input logic [N-1:0] p, input int dr,
                                                 input int dc, output bit ok);
        logic [N-1:0] res;
        int r, c, nr, nc;
        res = '0;
        ok  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                r  = i / W;
                c  = i % W;
                nr = r + dr;
                nc = c + dc;
                if (nr < 0 || nr >= H || nc < 0 || nc >= W) ok = 1'b0;
                else if (bg[nr*W + nc]) ok = 1'b0;
                else res[nr*W + nc] = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] make_piece(input int shape, input int row, input int col);
        int dr[4];
        int dc[4];
        logic [N-1:0] p;
        case (shape)
            0:       begin dr = '{0, 0, 1, 1}; dc = '{0, 1, 0, 1}; end
            1:       begin dr = '{0, 0, 0, 0}; dc = '{0, 1, 2, 3}; end
            2:       begin dr = '{0, 0, 0, 1}; dc = '{0, 1, 2, 1}; end
            default: begin dr = '{0, 0, 1, 1}; dc = '{1, 2, 0, 1}; end
        endcase
        p = '0;
        for (int k = 0; k < 4; k++) p[(row + dr[k])*W + col + dc[k]] = 1'b1;
        return p;
    endfunction

    task automatic clear_inputs();
        spawn_req      = 1'b0;
        spawn_location = '0;
        req_left       = 1'b0;
        req_right      = 1'b0;
        req_down       = 1'b0;
        req_drop       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        exp_q.delete();
        bg         = '0;
        model_cur  = '0;
        model_live = 1'b0;
        #1;
        check_vec("rst_cur", cur_location, '0);
        check_vec("rst_next", next_location, '0);
        check_vec("rst_lock_loc", lock_location, '0);
        check_int("rst_pulses", {29'd0, move_done, move_rejected, lock_valid}, 0);
        check_int("rst_busy_over", {30'd0, busy, game_over}, 2);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_spawn(input logic [N-1:0] loc);
        bit ok;
        int lat;
        ok  = ((loc & bg) == '0);
        lat = 0;
        @(posedge clk);
        #1;
        spawn_req      = 1'b1;
        spawn_location = loc;
        @(posedge clk);
        #1 spawn_req = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (!busy || game_over) begin
                lat = c;
                break;
            end
        end
        check_int("spawn_latency", lat, 1);
        check_int("spawn_game_over", int'(game_over), ok ? 0 : 1);
        check_vec("spawn_cur", cur_location, ok ? loc : '0);
        model_live = ok;
        model_cur  = ok ? loc : '0;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 50; c++) begin
            if (!busy) return;
            @(posedge clk);
            #1;
        end
        check_int("wait_ready_timeout", int'(busy), 0);
    endtask

    task automatic do_req(input bit l, input bit r, input bit d, input bit dp);
        logic [N-1:0] p, q;
        bit ok, will_lock, finished, first_busy;
        if (!(l | r | d | dp)) return;
        wait_ready();
        p         = model_cur;
        will_lock = 1'b0;
        if (dp) begin
            q = shift_piece(p, 1, 0, ok);
            while (ok) begin
                p = q;
                q = shift_piece(p, 1, 0, ok);
            end
            exp_q.push_back('{EV_LOCK, p});
            will_lock = 1'b1;
        end else if (d) begin
            q = shift_piece(p, 1, 0, ok);
            if (ok) begin
                p = q;
                exp_q.push_back('{EV_DONE, p});
            end else begin
                exp_q.push_back('{EV_REJ, p});
                exp_q.push_back('{EV_LOCK, p});
                will_lock = 1'b1;
            end
        end else begin
            q = shift_piece(p, 0, l ? -1 : 1, ok);
            if (ok) begin
                p = q;
                exp_q.push_back('{EV_DONE, p});
            end else begin
                exp_q.push_back('{EV_REJ, p});
            end
        end
        req_left  = l;
        req_right = r;
        req_down  = d;
        req_drop  = dp;
        @(posedge clk);
        #1;
        req_left  = 1'b0;
        req_right = 1'b0;
        req_down  = 1'b0;
        req_drop  = 1'b0;
        finished   = 1'b0;
        first_busy = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #2;
            if (c == 1) first_busy = busy;
            if (exp_q.size() == 0 && (will_lock ? busy : !busy)) begin
                finished = 1'b1;
                break;
            end
        end
        check_int("req_complete", int'(finished), 1);
        if (!dp && !will_lock) check_int("req_busy_after_commit", int'(first_busy), 0);
        if (will_lock) begin
            bg         = bg | p;
            model_live = 1'b0;
            model_cur  = '0;
        end else begin
            model_cur = p;
        end
        check_vec("req_cur", cur_location, model_cur);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] loc;
        int shape, row, col, rnd;

        // Spawn on an empty board.
        do_reset();
        do_spawn(150'hF);
        check_int("t1_busy", int'(busy), 0);

        // Left from column 0 is refused without wrapping to the row above.
        do_reset();
        loc = '0;
        for (int i = 120; i <= 123; i++) loc[i] = 1'b1;
        do_spawn(loc);
        do_req(1, 0, 0, 0);
        check_vec("t2_cur_unchanged", cur_location, loc);

        // Walk right to the last column; the next step must not wrap.
        do_reset();
        loc = '0;
        loc[4] = 1'b1;
        do_spawn(loc);
        repeat (6) do_req(0, 1, 0, 0);
        loc = '0;
        loc[9] = 1'b1;
        check_vec("t3_cur_col_last", cur_location, loc);

        // Hard drop onto a filled bottom row region.
        do_reset();
        for (int i = 134; i < N; i++) bg[i] = 1'b1;
        loc = '0;
        loc[114] = 1'b1;
        do_spawn(loc);
        do_req(0, 0, 0, 1);
        check_int("t4_busy_empty", int'(busy), 1);
        check_int("t4_bg_bit124", int'(bg[124]), 1);

        // Randomized play with simultaneous requests and accumulating background.
        do_reset();
        for (int piece = 0; piece < 10; piece++) begin
            shape = $urandom_range(0, 3);
            row   = $urandom_range(0, 1);
            col   = $urandom_range(0, W - 4);
            do_spawn(make_piece(shape, row, col));
            if (game_over) begin
                do_reset();
                continue;
            end
            for (int k = 0; k < 10 && model_live; k++) begin
                rnd = $urandom_range(0, 15);
                do_req(rnd[0], rnd[1], (rnd[3:2] == 2'b11), ($urandom_range(0, 7) == 0));
            end
            if (model_live) do_req(0, 0, 0, 1);
        end

        // Spawn collision ends the game; nothing afterwards moves or pulses.
        do_reset();
        bg[5] = 1'b1;
        do_spawn(150'h78);
        @(posedge clk);
        #1;
        spawn_req      = 1'b1;
        spawn_location = 150'hF;
        req_left       = 1'b1;
        req_down       = 1'b1;
        repeat (4) @(posedge clk);
        #1 clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_int("t5_game_over_sticky", int'(game_over), 1);
        check_int("t5_busy", int'(busy), 1);
        check_vec("t5_cur", cur_location, '0);

        // Reset in the middle of a hard drop aborts it without a lock pulse.
        do_reset();
        loc = '0;
        loc[4] = 1'b1;
        do_spawn(loc);
        wait_ready();
        req_drop = 1'b1;
        @(posedge clk);
        #1 req_drop = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_int("t6_mid_drop_busy", int'(busy), 1);
        do_reset();
        do_spawn(150'hF);
        do_req(0, 1, 0, 0);
        check_vec("t6_resume_cur", cur_location, 150'h1E);

        repeat (3) @(posedge clk);
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
